// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
// Shared constants for the fetch stage and the instruction decoder that sits
// behind it: address and instruction widths, the NOP encoding, the bit
// positions of the instruction fields, and the prefetch-queue counter width.
// No ports; imported by instr_fetch and fetch_fifo.

package instr_fetch_pkg;

  // Program counter / ROM address width and instruction word width
  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 16;

  // Prefetch queue depth; the queue logic is written for exactly two entries
  localparam int FETCH_DEPTH = 2;

  // Occupancy counter width, enough to hold 0..FETCH_DEPTH
  localparam int COUNT_W = 2;

  // Canonical no-operation instruction word
  localparam logic [INSTR_W-1:0] INSTR_NOP = 16'h3C00;

  // Instruction field positions: [15:14] reg select, [13:8] opcode, [7:0] data
  localparam int REG_SEL_MSB = 15;
  localparam int REG_SEL_LSB = 14;
  localparam int OPCODE_MSB  = 13;
  localparam int OPCODE_LSB  = 8;
  localparam int DATA_MSB    = 7;
  localparam int DATA_LSB    = 0;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } fetchEntry_t;

  // Next sequential fetch address; wraps silently at the top of the ROM
  function automatic logic [ADDR_W-1:0] pcIncrement(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo
// Two-entry in-order queue of {pc, word} pairs between the ROM return path and
// the decoder. Entry 0 is always the head, so the head outputs come straight
// from registers and stay stable while the decoder stalls.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset, clears contents and count
//   push_i       write pushPc_i/pushWord_i at the tail this cycle
//   pushPc_i     fetch address of the word being pushed
//   pushWord_i   instruction word being pushed
//   pop_i        remove the head this cycle (only meaningful when not empty)
//   flush_i      discard everything; wins over push and pop
//   count_o      number of valid entries (0..2)
//   headValid_o  queue is not empty
//   headPc_o     fetch address of the head entry
//   headWord_o   instruction word of the head entry

module fetch_fifo #(
  parameter int ADDR_W  = instr_fetch_pkg::ADDR_W,
  parameter int INSTR_W = instr_fetch_pkg::INSTR_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                push_i,
  input  logic [ADDR_W-1:0]                   pushPc_i,
  input  logic [INSTR_W-1:0]                  pushWord_i,
  input  logic                                pop_i,
  input  logic                                flush_i,
  output logic [instr_fetch_pkg::COUNT_W-1:0] count_o,
  output logic                                headValid_o,
  output logic [ADDR_W-1:0]                   headPc_o,
  output logic [INSTR_W-1:0]                  headWord_o
);

  import instr_fetch_pkg::*;

  logic [ADDR_W-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INSTR_W-1:0] word0_q, word0_d, word1_q, word1_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Next-state for the two slots. A pop shifts slot 1 into slot 0; a push
  // lands in the first free slot, taking the freed slot into account when
  // push and pop coincide. A flush only clears the count, since stale slot
  // contents are never visible while the count is zero.
  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    word0_d = word0_q;
    word1_d = word1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == '0) begin
            pc0_d   = pushPc_i;
            word0_d = pushWord_i;
          end else begin
            pc1_d   = pushPc_i;
            word1_d = pushWord_i;
          end
          count_d = count_q + COUNT_W'(1);
        end
        2'b01: begin
          pc0_d   = pc1_q;
          word0_d = word1_q;
          count_d = count_q - COUNT_W'(1);
        end
        2'b11: begin
          if (count_q == COUNT_W'(1)) begin
            pc0_d   = pushPc_i;
            word0_d = pushWord_i;
          end else begin
            pc0_d   = pc1_q;
            word0_d = word1_q;
            pc1_d   = pushPc_i;
            word1_d = pushWord_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Slot and count registers; reset also zeroes the data so the head
  // outputs read as zero straight out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc0_q   <= '0;
      pc1_q   <= '0;
      word0_q <= '0;
      word1_q <= '0;
      count_q <= '0;
    end else begin
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign headValid_o = (count_q != '0);
  assign headPc_o    = pc0_q;
  assign headWord_o  = word0_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Fetch stage in front of instruction_decoder. Owns the program counter,
// drives a registered (1-cycle latency) program ROM, buffers returned words in
// a two-entry prefetch queue and presents them over a valid/ready handshake.
// Execute-side redirects flush everything and restart at the target; halt
// stops new fetches while letting outstanding work drain.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   mem_rd         ROM read strobe; data returns on mem_data next cycle
//   mem_addr       ROM read address (current PC)
//   mem_data       ROM read data, valid the cycle after mem_rd
//   instr_valid    head of queue holds an instruction
//   instr_data     instruction word at the head
//   instr_pc       address the head instruction was fetched from
//   instr_ready    decoder accepts the head this cycle
//   redirect       one-cycle jump request
//   redirect_addr  jump target
//   halt           level; suppresses new fetches while high
//   pc_dbg         current PC for the debug bus

module instr_fetch #(
  parameter int ADDR_W     = instr_fetch_pkg::ADDR_W,
  parameter int INSTR_W    = instr_fetch_pkg::INSTR_W,
  parameter int DEPTH      = instr_fetch_pkg::FETCH_DEPTH,
  parameter int RESET_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc_dbg
);

  import instr_fetch_pkg::*;

  localparam int OCC_W = COUNT_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  inflightPc_q, inflightPc_d;
  logic               inflight_q, inflight_d;
  logic [COUNT_W-1:0] fifoCount;
  logic [OCC_W-1:0]   occupancy;
  logic               pop;
  logic               push;
  logic               issue;

  // A word returning from the ROM lands in the queue unless a redirect is
  // throwing it away this cycle.
  assign pop  = instr_valid & instr_ready;
  assign push = inflight_q & ~redirect;

  // Slots already claimed once this cycle settles: queued words plus the one
  // still in the ROM pipe, minus the head leaving now. A new read is only
  // started if its word is guaranteed a slot when it returns, which is what
  // keeps the queue from ever being pushed while full.
  assign occupancy = {1'b0, fifoCount} + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue     = ~rst & ~halt & ~redirect & (occupancy < OCC_W'(DEPTH));

  assign mem_rd   = issue;
  assign mem_addr = pc_q;
  assign pc_dbg   = pc_q;

  // PC and in-flight tracking. A redirect retargets the PC and starts
  // nothing; the in-flight flag drops so the word already in the ROM pipe is
  // never captured. The fetch address is remembered alongside the flag so it
  // can travel with the word into the queue.
  always_comb begin
    pc_d         = pc_q;
    inflight_d   = 1'b0;
    inflightPc_d = inflightPc_q;
    if (redirect) begin
      pc_d = redirect_addr;
    end else if (issue) begin
      pc_d         = pcIncrement(pc_q);
      inflight_d   = 1'b1;
      inflightPc_d = pc_q;
    end
  end

  // State registers for the PC side of the stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= ADDR_W'(RESET_ADDR);
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
    end
  end

  // Prefetch queue; a redirect flushes it even if the head is popped in the
  // same cycle, since that head has already been handed to the decoder.
  fetch_fifo #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .pushPc_i    (inflightPc_q),
    .pushWord_i  (mem_data),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (fifoCount),
    .headValid_o (instr_valid),
    .headPc_o    (instr_pc),
    .headWord_o  (instr_data)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Self-checking bench for instr_fetch. The ROM is modelled as a registered
// array holding 16'hA000 + address. A reference model keeps the list of
// instructions the stage owes the decoder (each with the cycle it may first
// appear); a monitor on the falling edge compares the DUT's handshake,
// head contents, ROM strobe and PC against that list.

module tb_instr_fetch;

  localparam int AW = 5;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_data = '0;
  logic          instr_valid;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          halt;
  logic [AW-1:0] pc_dbg;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .pc_dbg        (pc_dbg)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] word;
    int            avail;
  } expItem_t;

  expItem_t expQ[$];
  int       checks   = 0;
  int       errors   = 0;
  int       cyc      = 0;
  int       modelPc  = 0;
  int       rdPulses = 0;
  bit       started  = 1'b0;

  function automatic logic [IW-1:0] romWord(input int a);
    return 16'hA000 + 16'(a);
  endfunction

  // Registered program ROM
  always @(posedge clk) begin
    if (mem_rd) mem_data <= romWord(int'(mem_addr));
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: every fetch the stage should start becomes an owed
  // instruction visible two cycles later; reset and redirect cancel all owed
  // instructions that were not accepted before the edge.
  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      modelPc = 0;
      started = 1'b1;
    end else if (started) begin
      if (redirect) begin
        expQ.delete();
        modelPc = int'(redirect_addr);
      end else if (!halt && expQ.size() < 2) begin
        expQ.push_back('{pc: AW'(modelPc), word: romWord(modelPc), avail: cyc + 2});
        modelPc = (modelPc + 1) % 32;
      end
    end
    cyc++;
  end

  // Monitor: compares DUT outputs mid-cycle and consumes owed instructions
  // when the decoder accepts them.
  always @(negedge clk) begin : monitor
    bit expValid;
    bit expRd;
    bit pushWhenFull;
    if (started) begin
      expValid = (expQ.size() > 0) && (expQ[0].avail <= cyc);
      checkOutput("instr_valid", longint'(instr_valid), longint'(expValid));
      if (expValid) begin
        checkOutput("instr_pc", longint'(instr_pc), longint'(expQ[0].pc));
        checkOutput("instr_data", longint'(instr_data), longint'(expQ[0].word));
        if (instr_ready) void'(expQ.pop_front());
      end
      expRd = !rst && !halt && !redirect && (expQ.size() < 2);
      checkOutput("mem_rd", longint'(mem_rd), longint'(expRd));
      checkOutput("mem_addr", longint'(mem_addr), longint'(modelPc));
      checkOutput("pc_dbg", longint'(pc_dbg), longint'(modelPc));
      pushWhenFull = dut.inflight_q && !redirect && !rst &&
                     !(instr_valid && instr_ready) && (dut.fifoCount == 2'd2);
      checkOutput("noPushWhenFull", longint'(pushWhenFull), 0);
      if (mem_rd) rdPulses++;
    end
  end

  // One cycle of stimulus; returns just after the closing clock edge
  task automatic applyStimulus(input bit rdy, input bit rdr, input int raddr, input bit h, input bit r);
    instr_ready   = rdy;
    redirect      = rdr;
    redirect_addr = AW'(raddr);
    halt          = h;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit hl;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    halt          = 1'b0;
    rst           = 1'b1;

    // Reset state
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("resetValid", longint'(instr_valid), 0);
    checkOutput("resetPc", longint'(pc_dbg), 0);
    checkOutput("resetInstrPc", longint'(instr_pc), 0);
    checkOutput("resetInstrData", longint'(instr_data), 0);

    // Free-running stream from address 0
    repeat (12) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Decoder stalled for 6 cycles after reset: exactly two reads
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
    rdPulses = 0;
    repeat (6) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("stallReadCount", rdPulses, 2);
    checkOutput("stallPc", longint'(pc_dbg), 2);
    checkOutput("stallHeadPc", longint'(instr_pc), 0);
    repeat (8) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Redirect to 12 with the queue full
    repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 12, 1'b0, 1'b0);
    checkOutput("redirectPc", longint'(pc_dbg), 12);
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("redirectValid", longint'(instr_valid), 1);
    checkOutput("redirectHeadPc", longint'(instr_pc), 12);
    checkOutput("redirectHeadData", longint'(instr_data), 16'hA00C);
    repeat (6) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Redirect near the top of the ROM; delivery wraps 30,31,0,1
    applyStimulus(1'b1, 1'b1, 30, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Halt mid-stream: no reads, queue drains
    rdPulses = 0;
    repeat (5) applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("haltReadCount", rdPulses, 0);
    checkOutput("haltDrained", longint'(instr_valid), 0);
    repeat (6) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Redirect to 7 while halted
    rdPulses = 0;
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 7, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("haltRedirectPc", longint'(pc_dbg), 7);
    checkOutput("haltRedirectReads", rdPulses, 0);
    repeat (6) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Reset with the queue full and the decoder stalled
    repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("midResetValid", longint'(instr_valid), 0);
    checkOutput("midResetPc", longint'(pc_dbg), 0);
    repeat (8) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Random traffic
    hl = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 9) == 0) hl = !hl;
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                    int'($urandom_range(0, 31)), hl, $urandom_range(0, 99) == 0);
    end

    repeat (4) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that sits directly upstream of instruction_decoder. It owns the program counter and drives the read address of a registered (1-cycle latency) program ROM. It buffers fetched 16-bit instruction words in a 2-entry prefetch queue and hands them to the decoder over a valid/ready handshake. It accepts redirect requests (jumps) and halt requests from the execute side.

Parameters:
ADDR_W, 5, program counter / ROM address width
INSTR_W, 16, instruction word width (bits 15:14 reg select, 13:8 opcode, 7:0 data)
DEPTH, 2, prefetch queue entries (fixed at 2; other values unsupported)
RESET_ADDR, 0, PC value after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
mem_rd  out  1  ROM read strobe; data returns on mem_data in the following cycle
mem_addr  out  ADDR_W  ROM read address (current PC)
mem_data  in  INSTR_W  ROM read data, valid in the cycle after mem_rd
instr_valid  out  1  head of queue holds a valid instruction
instr_data  out  INSTR_W  instruction word at head of queue
instr_pc  out  ADDR_W  address the head instruction was fetched from
instr_ready  in  1  decoder accepts head this cycle
redirect  in  1  one-cycle jump request
redirect_addr  in  ADDR_W  jump target
halt  in  1  level; suppresses new fetches while high
pc_dbg  out  ADDR_W  current PC, for the debug bus

Behaviour:
- Reset (rst=1 at an edge, regardless of state): PC=RESET_ADDR, queue empty, in-flight flag=0, instr_valid=0, mem_rd=0. instr_data/instr_pc=0. Reset mid-operation discards in-flight data.
- pop = instr_valid & instr_ready. push = inflight & !redirect (mem_data is captured at the end of that cycle, together with its fetch PC).
- Issue: mem_rd = !rst & !halt & !redirect & (count + inflight - pop < DEPTH). mem_addr = PC at all times.
- On each issue: PC <= PC+1 (mod 2^ADDR_W, so 31 wraps to 0 with no flag), and inflight <= 1. Otherwise inflight <= 0.
- Latency: mem_rd in cycle N, capture at end of N+1, instr_valid high in N+2. There is no bypass.
- Throughput: 1 instruction/cycle sustained with instr_ready held high after the initial 2-cycle fill.
- Queue is in-order. A simultaneous push and pop is legal at any count, including full. A push when count=DEPTH cannot occur by construction; the bench must assert this never happens.
- Redirect (highest priority after reset):
  - Queue is flushed (count <= 0).
  - In-flight return is dropped.
  - PC <= redirect_addr.
  - No issue in the redirect cycle.
  - A pop in the same cycle counts as accepted by the decoder; the flush still applies.
  - First issue at target in R+1; instr_valid at R+3.
  - Redirect during halt updates PC but issues nothing.
- Halt: no new issues. An outstanding in-flight word still lands, and the queue drains normally. Deasserting halt resumes from the held PC the next cycle.
- instr_data and instr_pc are stable while instr_valid=1 and instr_ready=0.
- pc_dbg = PC.

Decomposition:
- Shared constants file (alongside existing instruction definitions): ADDR_W, INSTR_W, NOP encoding (16'h3C00), field bit positions.
- One sub-module: fetch_fifo. It is a 2-entry synchronous FIFO carrying {pc, word}, with push, pop, flush, count, and head outputs.
- instr_fetch holds the PC, in-flight flag, issue logic, and redirect logic.

Test Plan:
- Release rst with instr_ready=1 and ROM loaded with word k = 16'hA000+k. Expected: mem_addr 0,1,2,… on consecutive cycles; instr_valid first high 2 cycles after the first mem_rd; instr_pc 0,1,2,… with matching data and no gaps.
- Hold instr_ready=0 for 6 cycles after reset. Expected: exactly 2 mem_rd pulses; queue holds PC 0 and 1; PC=2. On release: 0,1,2,3 delivered in order, nothing lost or duplicated.
- With the queue full and a read in flight, pulse redirect with redirect_addr=12. Expected: no mem_rd that cycle; mem_addr=12 next cycle; first instr_valid shows instr_pc=12 three cycles after redirect; PCs 1/2 never appear afterwards.
- redirect_addr=30 with free-running ready. Expected: instr_pc sequence 30,31,0,1.
- Raise halt for 5 cycles mid-stream. Expected: mem_rd low throughout; the in-flight word still delivered; instr_valid drops after drain; resumes at the next PC after halt falls. Repeat with redirect=1 to address 7 during halt: expected no fetch until halt falls, then instr_pc=7.
- Assert rst for 1 cycle with the queue full and ready=0. Expected next cycle: instr_valid=0, mem_rd=0, PC=0; the stale in-flight word is never delivered; refetch starts from 0.
